// File: rtl/ysyx_23060025_id_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_id_issue_pkg
// Description : Shared types and constants for the ID issue stage: issue FSM
//               state encoding, default operand/control widths and a
//               saturating-increment helper used by the optional counters.
//               Optional performance counters are enabled by defining the
//               macro YSYX_23060025_ISSUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060025_id_issue_pkg;

    // Default operand / PC width
    localparam int unsigned c_XLEN_DEFAULT   = 32;
    // Default width of the opaque decoded-control bundle
    localparam int unsigned c_CTRL_W_DEFAULT = 48;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,   // no hazard in progress
        ST_WAIT = 2'd1,   // hazard unit is requesting a stall
        ST_CAPT = 2'd2    // bypass data captured, waiting for an output slot
    } issue_state_e;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage : ysyx_23060025_id_issue_pkg
`default_nettype wire

// File: rtl/ysyx_23060025_id_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_id_issue_if
// Description : ID/EX issue bus: valid/ready handshake plus the registered
//               PC, control bundle and operands presented to the EXU.
//               master = issue stage, slave = EXU.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_23060025_id_issue_if #(
    parameter int XLEN   = ysyx_23060025_id_issue_pkg::c_XLEN_DEFAULT,
    parameter int CTRL_W = ysyx_23060025_id_issue_pkg::c_CTRL_W_DEFAULT
);
    logic              exu_valid_o;
    logic              exu_ready_i;
    logic [XLEN-1:0]   exu_pc_o;
    logic [CTRL_W-1:0] exu_ctrl_o;
    logic [XLEN-1:0]   exu_src1_o;
    logic [XLEN-1:0]   exu_src2_o;
    logic [XLEN-1:0]   exu_csr_o;

    modport master (
        output exu_valid_o,
        output exu_pc_o,
        output exu_ctrl_o,
        output exu_src1_o,
        output exu_src2_o,
        output exu_csr_o,
        input  exu_ready_i
    );

    modport slave (
        input  exu_valid_o,
        input  exu_pc_o,
        input  exu_ctrl_o,
        input  exu_src1_o,
        input  exu_src2_o,
        input  exu_csr_o,
        output exu_ready_i
    );

endinterface : ysyx_23060025_id_issue_if
`default_nettype wire

// File: rtl/ysyx_23060025_id_operand_hold.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_id_operand_hold
// Description : Per-operand hazard bookkeeping for the issue stage: a sticky
//               "needs bypass" flag, a hold register that keeps the one-cycle
//               bypass value alive while the output slot is busy, and the
//               source mux choosing between hold, bypass and register file.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_id_operand_hold #(
    parameter int XLEN = ysyx_23060025_id_issue_pkg::c_XLEN_DEFAULT
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            pend_set_i,   // stall cycle: sample conflict
    input  wire logic            conflict_i,   // RAW hazard on this operand
    input  wire logic            pend_clr_i,   // accept / flush / abandon
    input  wire logic            capture_i,    // latch the selected source
    input  wire logic            use_hold_i,   // drive operand from hold reg
    input  wire logic [XLEN-1:0] bypass_i,
    input  wire logic [XLEN-1:0] rf_i,
    output logic      [XLEN-1:0] operand_o
);

    logic            r_pend;
    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] w_sel;

    // Bypass is only meaningful for an operand flagged during the stall
    assign w_sel     = r_pend ? bypass_i : rf_i;
    assign operand_o = use_hold_i ? r_hold : w_sel;

    // Sticky pend flag and hold register; clear takes priority over set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_hold <= '0;
        end else begin
            if (pend_clr_i) begin
                r_pend <= 1'b0;
            end else if (pend_set_i && conflict_i) begin
                r_pend <= 1'b1;
            end
            if (capture_i) begin
                r_hold <= w_sel;
            end
        end
    end

endmodule : ysyx_23060025_id_operand_hold
`default_nettype wire

// File: rtl/ysyx_23060025_id_issue.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_id_issue
// Description : Decode-to-execute issue stage and ID/EX pipeline register.
//               Holds the decoded instruction across hazard-unit stalls,
//               captures one-cycle-valid bypass data, merges it with the
//               register-file operands and issues one instruction at a time
//               to the EXU over a valid/ready handshake.
//               Define YSYX_23060025_ISSUE_PERF_EN to add the saturating
//               stall_cycles_o / bubble_cnt_o performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_id_issue
    import ysyx_23060025_id_issue_pkg::*;
#(
    parameter int XLEN   = c_XLEN_DEFAULT,
    parameter int CTRL_W = c_CTRL_W_DEFAULT
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              flush_i,
    // decoder side
    input  wire logic              idu_valid_i,
    output logic                   idu_ready_o,
    input  wire logic [XLEN-1:0]   idu_pc_i,
    input  wire logic [CTRL_W-1:0] idu_ctrl_i,
    input  wire logic [XLEN-1:0]   idu_rs1_data_i,
    input  wire logic [XLEN-1:0]   idu_rs2_data_i,
    input  wire logic [XLEN-1:0]   idu_csr_data_i,
    output logic                   idu_busy_o,
    // hazard unit side
    input  wire logic              conflict_reg1_i,
    input  wire logic              conflict_reg2_i,
    input  wire logic              conflict_csr_i,
    input  wire logic              conflict_id_nop_i,
    input  wire logic [XLEN-1:0]   conflict_reg1_bypass_data_i,
    input  wire logic [XLEN-1:0]   conflict_reg2_bypass_data_i,
    input  wire logic [XLEN-1:0]   conflict_csr_bypass_data_i,
    // EXU side
    ysyx_23060025_id_issue_if.master exu
`ifdef YSYX_23060025_ISSUE_PERF_EN
    ,
    output logic [31:0]            stall_cycles_o,
    output logic [31:0]            bubble_cnt_o
`endif
);

    issue_state_e      r_state;
    logic              r_exu_valid;
    logic [XLEN-1:0]   r_exu_pc;
    logic [CTRL_W-1:0] r_exu_ctrl;
    logic [XLEN-1:0]   r_exu_src1;
    logic [XLEN-1:0]   r_exu_src2;
    logic [XLEN-1:0]   r_exu_csr;

    logic              w_run;
    logic              w_wait;
    logic              w_capt;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_capture;
    logic [XLEN-1:0]   w_src1;
    logic [XLEN-1:0]   w_src2;
    logic [XLEN-1:0]   w_csr;

    assign w_run  = (r_state == ST_RUN);
    assign w_wait = (r_state == ST_WAIT);
    assign w_capt = (r_state == ST_CAPT);

    // Output register can take a new instruction when empty or draining
    assign w_slot_free = ~r_exu_valid | exu.exu_ready_i;

    // Flush blocks acceptance so a redirected instruction never issues
    assign idu_ready_o = ~flush_i & w_slot_free &
                         (((w_run | w_wait) & ~conflict_id_nop_i) | w_capt);
    assign w_accept    = idu_valid_i & idu_ready_o;
    assign idu_busy_o  = idu_valid_i;

    // Conflicts are only sampled while the hazard unit asserts the stall
    assign w_pend_set = idu_valid_i & conflict_id_nop_i & (w_run | w_wait);

    // Pend flags die with the instruction: accepted, flushed, or leaving
    // WAIT straight back to RUN
    assign w_pend_clr = flush_i | w_accept |
                        (w_wait & ~conflict_id_nop_i & w_slot_free);

    // Bypass data lives one cycle; park it if the slot is still occupied
    assign w_capture  = ~flush_i & w_wait & ~conflict_id_nop_i & ~w_slot_free;

    // CSR bypass is same-cycle valid, so it is selected at accept time
    assign w_csr = conflict_csr_i ? conflict_csr_bypass_data_i : idu_csr_data_i;

    ysyx_23060025_id_operand_hold #(
        .XLEN (XLEN)
    ) u_hold_rs1 (
        .clock      (clock),
        .reset      (reset),
        .pend_set_i (w_pend_set),
        .conflict_i (conflict_reg1_i),
        .pend_clr_i (w_pend_clr),
        .capture_i  (w_capture),
        .use_hold_i (w_capt),
        .bypass_i   (conflict_reg1_bypass_data_i),
        .rf_i       (idu_rs1_data_i),
        .operand_o  (w_src1)
    );

    ysyx_23060025_id_operand_hold #(
        .XLEN (XLEN)
    ) u_hold_rs2 (
        .clock      (clock),
        .reset      (reset),
        .pend_set_i (w_pend_set),
        .conflict_i (conflict_reg2_i),
        .pend_clr_i (w_pend_clr),
        .capture_i  (w_capture),
        .use_hold_i (w_capt),
        .bypass_i   (conflict_reg2_bypass_data_i),
        .rf_i       (idu_rs2_data_i),
        .operand_o  (w_src2)
    );

    // Issue FSM and ID/EX output register; flush wins over everything
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_exu_valid <= 1'b0;
            r_exu_pc    <= '0;
            r_exu_ctrl  <= '0;
            r_exu_src1  <= '0;
            r_exu_src2  <= '0;
            r_exu_csr   <= '0;
        end else if (flush_i) begin
            r_state     <= ST_RUN;
            r_exu_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (idu_valid_i && conflict_id_nop_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!conflict_id_nop_i) begin
                        r_state <= w_slot_free ? ST_RUN : ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (w_slot_free) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if (w_accept) begin
                r_exu_valid <= 1'b1;
                r_exu_pc    <= idu_pc_i;
                r_exu_ctrl  <= idu_ctrl_i;
                r_exu_src1  <= w_src1;
                r_exu_src2  <= w_src2;
                r_exu_csr   <= w_csr;
            end else if (exu.exu_ready_i) begin
                r_exu_valid <= 1'b0;
            end
        end
    end

    assign exu.exu_valid_o = r_exu_valid;
    assign exu.exu_pc_o    = r_exu_pc;
    assign exu.exu_ctrl_o  = r_exu_ctrl;
    assign exu.exu_src1_o  = r_exu_src1;
    assign exu.exu_src2_o  = r_exu_src2;
    assign exu.exu_csr_o   = r_exu_csr;

`ifdef YSYX_23060025_ISSUE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cnt;

    // Saturating stall / bubble counters; only reset clears them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_bubble_cnt   <= '0;
        end else begin
            if (!w_run) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (!r_exu_valid && idu_valid_i) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign bubble_cnt_o   = r_bubble_cnt;
`endif

endmodule : ysyx_23060025_id_issue
`default_nettype wire

// File: tb/tb_ysyx_23060025_id_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060025_id_issue
// Description : Directed, table-driven bench for the ID issue stage plus
//               hand-written flush and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060025_id_issue;

    logic        clock;
    logic        reset;
    logic        flush_i;
    logic        idu_valid_i;
    logic        idu_ready_o;
    logic [31:0] idu_pc_i;
    logic [47:0] idu_ctrl_i;
    logic [31:0] idu_rs1_data_i;
    logic [31:0] idu_rs2_data_i;
    logic [31:0] idu_csr_data_i;
    logic        idu_busy_o;
    logic        conflict_reg1_i;
    logic        conflict_reg2_i;
    logic        conflict_csr_i;
    logic        conflict_id_nop_i;
    logic [31:0] conflict_reg1_bypass_data_i;
    logic [31:0] conflict_reg2_bypass_data_i;
    logic [31:0] conflict_csr_bypass_data_i;
`ifdef YSYX_23060025_ISSUE_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] bubble_cnt_o;
`endif

    int n_checks = 0;
    int n_err    = 0;

    ysyx_23060025_id_issue_if #(.XLEN(32), .CTRL_W(48)) exu_bus ();

    ysyx_23060025_id_issue #(.XLEN(32), .CTRL_W(48)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .flush_i                     (flush_i),
        .idu_valid_i                 (idu_valid_i),
        .idu_ready_o                 (idu_ready_o),
        .idu_pc_i                    (idu_pc_i),
        .idu_ctrl_i                  (idu_ctrl_i),
        .idu_rs1_data_i              (idu_rs1_data_i),
        .idu_rs2_data_i              (idu_rs2_data_i),
        .idu_csr_data_i              (idu_csr_data_i),
        .idu_busy_o                  (idu_busy_o),
        .conflict_reg1_i             (conflict_reg1_i),
        .conflict_reg2_i             (conflict_reg2_i),
        .conflict_csr_i              (conflict_csr_i),
        .conflict_id_nop_i           (conflict_id_nop_i),
        .conflict_reg1_bypass_data_i (conflict_reg1_bypass_data_i),
        .conflict_reg2_bypass_data_i (conflict_reg2_bypass_data_i),
        .conflict_csr_bypass_data_i  (conflict_csr_bypass_data_i),
        .exu                         (exu_bus)
`ifdef YSYX_23060025_ISSUE_PERF_EN
        ,
        .stall_cycles_o              (stall_cycles_o),
        .bubble_cnt_o                (bubble_cnt_o)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        v, n, c1, c2, cc, r;
        logic [31:0] pc, rf1, rf2, csr, b1, b2, bc;
        logic        e_rdy, e_val;
        logic [31:0] e_pc, e_s1, e_s2, e_csr;
    } vec_t;

    function automatic vec_t mk(
        input logic v, n, c1, c2, cc, r,
        input logic [31:0] pc, rf1, rf2, csr, b1, b2, bc,
        input logic e_rdy, e_val,
        input logic [31:0] e_pc, e_s1, e_s2, e_csr);
        vec_t t;
        t.v = v; t.n = n; t.c1 = c1; t.c2 = c2; t.cc = cc; t.r = r;
        t.pc = pc; t.rf1 = rf1; t.rf2 = rf2; t.csr = csr;
        t.b1 = b1; t.b2 = b2; t.bc = bc;
        t.e_rdy = e_rdy; t.e_val = e_val;
        t.e_pc = e_pc; t.e_s1 = e_s1; t.e_s2 = e_s2; t.e_csr = e_csr;
        return t;
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check ready, check registered outputs
    task automatic apply(input vec_t t, input logic fl, input string tag);
        @(negedge clock);
        flush_i                     = fl;
        idu_valid_i                 = t.v;
        conflict_id_nop_i           = t.n;
        conflict_reg1_i             = t.c1;
        conflict_reg2_i             = t.c2;
        conflict_csr_i              = t.cc;
        exu_bus.exu_ready_i         = t.r;
        idu_pc_i                    = t.pc;
        idu_ctrl_i                  = {16'hC0DE, t.pc};
        idu_rs1_data_i              = t.rf1;
        idu_rs2_data_i              = t.rf2;
        idu_csr_data_i              = t.csr;
        conflict_reg1_bypass_data_i = t.b1;
        conflict_reg2_bypass_data_i = t.b2;
        conflict_csr_bypass_data_i  = t.bc;
        #1;
        chk(tag, "idu_ready", 64'(idu_ready_o), 64'(t.e_rdy));
        chk(tag, "idu_busy",  64'(idu_busy_o),  64'(t.v));
        @(posedge clock);
        #1;
        chk(tag, "exu_valid", 64'(exu_bus.exu_valid_o), 64'(t.e_val));
        if (t.e_val) begin
            chk(tag, "exu_pc",   64'(exu_bus.exu_pc_o),   64'(t.e_pc));
            chk(tag, "exu_ctrl", 64'(exu_bus.exu_ctrl_o), 64'({16'hC0DE, t.e_pc}));
            chk(tag, "exu_src1", 64'(exu_bus.exu_src1_o), 64'(t.e_s1));
            chk(tag, "exu_src2", 64'(exu_bus.exu_src2_o), 64'(t.e_s2));
            chk(tag, "exu_csr",  64'(exu_bus.exu_csr_o),  64'(t.e_csr));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "exu_valid", 64'(exu_bus.exu_valid_o), 64'd0);
        chk(tag, "exu_pc",    64'(exu_bus.exu_pc_o),    64'd0);
        chk(tag, "exu_ctrl",  64'(exu_bus.exu_ctrl_o),  64'd0);
        chk(tag, "exu_src1",  64'(exu_bus.exu_src1_o),  64'd0);
        chk(tag, "exu_src2",  64'(exu_bus.exu_src2_o),  64'd0);
        chk(tag, "exu_csr",   64'(exu_bus.exu_csr_o),   64'd0);
`ifdef YSYX_23060025_ISSUE_PERF_EN
        chk(tag, "stall_cycles", 64'(stall_cycles_o), 64'd0);
        chk(tag, "bubble_cnt",   64'(bubble_cnt_o),   64'd0);
`endif
    endtask

    vec_t tbl[16];
    localparam logic [31:0] B = 32'h8000_0000;

    initial begin
        //              v  n  c1 c2 cc r   pc      rf1    rf2    csr    b1            b2            bc          rdy val  e_pc    e_s1          e_s2          e_csr
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, B+32'h00, 32'h01, 32'h02, 32'h03, 0,            0,            0,          1, 1, B+32'h00, 32'h01,        32'h02,        32'h03);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, B+32'h04, 32'h14, 32'h24, 32'h34, 0,            0,            0,          1, 1, B+32'h04, 32'h14,        32'h24,        32'h34);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, B+32'h08, 32'h18, 32'h28, 32'h38, 0,            0,            0,          1, 1, B+32'h08, 32'h18,        32'h28,        32'h38);
        tbl[3]  = mk(1, 1, 1, 0, 0, 1, B+32'h0C, 32'h11, 32'h22, 32'h33, 0,            0,            0,          0, 0, 0,        0,             0,             0);
        tbl[4]  = mk(1, 1, 1, 0, 0, 1, B+32'h0C, 32'h11, 32'h22, 32'h33, 0,            0,            0,          0, 0, 0,        0,             0,             0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, B+32'h0C, 32'h11, 32'h22, 32'h33, 32'hDEADBEEF, 0,            0,          1, 1, B+32'h0C, 32'hDEADBEEF,  32'h22,        32'h33);
        tbl[6]  = mk(1, 0, 0, 0, 1, 1, B+32'h10, 32'h05, 32'h06, 32'h00, 0,            0,            32'h1800,   1, 1, B+32'h10, 32'h05,        32'h06,        32'h1800);
        tbl[7]  = mk(1, 1, 1, 0, 0, 0, B+32'h14, 32'h11, 32'h77, 32'h44, 0,            0,            0,          0, 1, B+32'h10, 32'h05,        32'h06,        32'h1800);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, B+32'h14, 32'h11, 32'h77, 32'h44, 32'hDEADBEEF, 0,            0,          0, 1, B+32'h10, 32'h05,        32'h06,        32'h1800);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, B+32'h14, 32'h11, 32'h77, 32'h44, 0,            0,            0,          0, 1, B+32'h10, 32'h05,        32'h06,        32'h1800);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, B+32'h14, 32'h11, 32'h77, 32'h44, 0,            0,            0,          0, 1, B+32'h10, 32'h05,        32'h06,        32'h1800);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, B+32'h14, 32'h11, 32'h77, 32'h44, 0,            0,            0,          1, 1, B+32'h14, 32'hDEADBEEF,  32'h77,        32'h44);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0,        0,      0,      0,      0,            0,            0,          1, 0, 0,        0,             0,             0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,        0,      0,      0,      0,            0,            0,          1, 0, 0,        0,             0,             0);
        tbl[14] = mk(1, 1, 0, 1, 0, 1, B+32'h18, 32'h0A, 32'h0B, 32'h0C, 0,            0,            0,          0, 0, 0,        0,             0,             0);
        tbl[15] = mk(1, 0, 0, 0, 0, 1, B+32'h18, 32'h0A, 32'h0B, 32'h0C, 32'h99,       32'hCAFE0000, 0,          1, 1, B+32'h18, 32'h0A,        32'hCAFE0000,  32'h0C);

        // Quiet inputs and reset
        reset = 1'b1;
        flush_i = 1'b0; idu_valid_i = 1'b0; conflict_id_nop_i = 1'b0;
        conflict_reg1_i = 1'b0; conflict_reg2_i = 1'b0; conflict_csr_i = 1'b0;
        exu_bus.exu_ready_i = 1'b0;
        idu_pc_i = '0; idu_ctrl_i = '0; idu_rs1_data_i = '0; idu_rs2_data_i = '0;
        idu_csr_data_i = '0; conflict_reg1_bypass_data_i = '0;
        conflict_reg2_bypass_data_i = '0; conflict_csr_bypass_data_i = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Table: back-to-back issue, rs1/rs2 hazards, CSR bypass, CAPT path
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Flush during WAIT drops the pend flag and returns to RUN
        apply(mk(1, 1, 1, 0, 0, 1, B+32'h20, 32'h55, 32'h66, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0), 1'b0, "flush_enter_wait");
        apply(mk(1, 1, 1, 0, 0, 1, B+32'h20, 32'h55, 32'h66, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0), 1'b1, "flush_in_wait");
        apply(mk(1, 0, 0, 0, 0, 1, B+32'h24, 32'h57, 32'h66, 0, 32'hBAD, 0, 0,
                 1, 1, B+32'h24, 32'h57, 32'h66, 0), 1'b0, "after_flush");

        // Flush with a valid output: valid drops, data registers kept
        apply(mk(1, 0, 0, 0, 0, 1, B+32'h28, 32'h01, 32'h02, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0), 1'b1, "flush_valid_out");
        chk("flush_valid_out", "exu_pc_kept",   64'(exu_bus.exu_pc_o),   64'(B+32'h24));
        chk("flush_valid_out", "exu_src1_kept", 64'(exu_bus.exu_src1_o), 64'h57);

        // Reach CAPT, then assert reset asynchronously mid-cycle
        apply(mk(1, 0, 0, 0, 0, 1, B+32'h2C, 32'h03, 32'h04, 32'h05, 0, 0, 0,
                 1, 1, B+32'h2C, 32'h03, 32'h04, 32'h05), 1'b0, "pre_capt_issue");
        apply(mk(1, 1, 1, 0, 0, 0, B+32'h30, 32'h11, 32'h12, 32'h13, 0, 0, 0,
                 0, 1, B+32'h2C, 32'h03, 32'h04, 32'h05), 1'b0, "capt_wait");
        apply(mk(1, 0, 0, 0, 0, 0, B+32'h30, 32'h11, 32'h12, 32'h13, 32'hDEADBEEF, 0, 0,
                 0, 1, B+32'h2C, 32'h03, 32'h04, 32'h05), 1'b0, "capt_enter");
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0), 1'b0, "post_reset_idle");
        apply(mk(1, 0, 0, 0, 0, 1, B+32'h40, 32'h41, 32'h42, 32'h43, 32'hBAD, 0, 0,
                 1, 1, B+32'h40, 32'h41, 32'h42, 32'h43), 1'b0, "post_reset_issue");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ysyx_23060025_id_issue
`default_nettype wire
